pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache and data-cache controllers.
- Each cache controller keeps its normal pmem handshake: hold read/write until resp, with one-line transfers.
- The arbiter picks one requester at a time by round-robin, latches its command, drives pmem from registers, and routes pmem_resp back only to the granted side.
- Sits between the two cache_control/datapath pairs and the pmem model.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word / lc3b_pmem_addr).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line-fill request.
- i_pmem_address  in  ADDR_W  I-cache line address; low 4 bits are zero.
- i_pmem_rdata  out  LINE_W  fill data to I-cache.
- i_pmem_resp  out  1  I-cache transaction done.
- d_pmem_read  in  1  D-cache line-fill request.
- d_pmem_write  in  1  D-cache write-back request.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache write-back data.
- d_pmem_rdata  out  LINE_W  fill data to D-cache.
- d_pmem_resp  out  1  D-cache transaction done.
- pmem_read  out  1  read command to memory.
- pmem_write  out  1  write command to memory.
- pmem_address  out  ADDR_W  memory line address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory done.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, last_grant=D.
  - All latched command, address and data registers cleared.
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0 and pmem_address is 0 while reset is held and after release.
- States are IDLE, SERVE_I, SERVE_D and RELEASE.
- IDLE:
  - req_i = i_pmem_read; req_d = d_pmem_read | d_pmem_write.
  - Only req_i: go to SERVE_I.
  - Only req_d: go to SERVE_D.
  - Both: grant the side that is not last_grant (after reset, I wins the first tie).
  - Neither: stay in IDLE.
  - On the grant edge, latch that requester's read, write, address and wdata into the command registers.
- Command registers for I: read=1, write=0, wdata=0.
- If D asserts read and write together, write wins: latched write=1, read=0.
- SERVE_x:
  - pmem_read, pmem_write, pmem_address and pmem_wdata come only from the command registers.
  - They stay stable for the whole transaction, even if requester inputs change.
  - Grant-to-pmem latency is exactly 1 cycle: the request is sampled in IDLE, and the command is visible in the next cycle.
  - While pmem_resp=0, stay in SERVE_x.
  - When pmem_resp=1, the granted side's resp (i_pmem_resp or d_pmem_resp) is driven 1 combinationally in that same cycle.
  - The other side's resp stays 0.
  - On that edge: next state is RELEASE, last_grant is set to x, and the command registers are cleared.
- RELEASE:
  - Lasts exactly one cycle.
  - pmem commands are 0 and both resp outputs are 0.
  - Next state is IDLE.
  - This cycle lets the requester's controller leave its fetch/write-back state before requests are sampled again.
- rdata: i_pmem_rdata = d_pmem_rdata = pmem_rdata at all times (unregistered). Only the resp signals qualify the data.
- pmem_resp arriving in IDLE or RELEASE is ignored: no resp is forwarded and there is no state change.
- If the requester drops its request mid-service, the latched transaction still completes and its resp is still pulsed.
- If the same side re-requests immediately after RELEASE while the other side is waiting, the other side wins. This bounds wait time to one transaction.
- Minimum spacing between back-to-back transactions: commands are deasserted for 2 cycles (the resp-to-RELEASE edge, then IDLE).
- A mid-transaction reset abandons the transaction: outputs drop to 0 immediately. The memory model must tolerate the abandoned request.

Test Plan:
- Reset, then I only:
  - Stimulus: i_pmem_read=1, i_pmem_address=16'h1230; pmem answers with resp after 3 cycles, rdata=128'hA5..A5.
  - Required: pmem_read=1 and address 16'h1230 from the cycle after the request.
  - Required: i_pmem_resp=1 for one cycle with rdata A5..A5; d_pmem_resp=0 throughout.
- Simultaneous requests after reset:
  - Stimulus: i read to 16'h0040 and d write to 16'h8000 with wdata 128'h1 arrive together.
  - Required: I is served first, then RELEASE, then IDLE, then D is served.
  - Required: pmem_write=1, address 16'h8000, wdata 128'h1.
- Continuous contention:
  - Stimulus: both sides hold requests for 4 transactions.
  - Required: grant order is I, D, I, D.
  - Required: each resp pulse is exactly 1 cycle, and commands are 0 for exactly 2 cycles between transactions.
- Input change mid-service:
  - Stimulus: d read to 16'h0100 is granted, then D changes its address to 16'h0200 and later drops d_pmem_read before pmem_resp.
  - Required: pmem_address stays 16'h0100 until resp, and d_pmem_resp still pulses.
- D read and write asserted together:
  - Required: pmem_write=1, pmem_read=0.
- Stray pmem_resp and reset mid-transaction:
  - Stimulus: pmem_resp pulses while in IDLE.
  - Required: no resp is forwarded.
  - Stimulus: rst_n pulled low during SERVE_D.
  - Required: pmem_write/pmem_read go to 0 asynchronously.
  - Required: after release the arbiter is in IDLE and I wins the next tie.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Bundle of the three pmem handshakes around the arbiter:
// I-cache side, D-cache side and physical memory side.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter view.
    modport slave (
        input  i_pmem_read,
        input  i_pmem_address,
        output i_pmem_rdata,
        output i_pmem_resp,
        input  d_pmem_read,
        input  d_pmem_write,
        input  d_pmem_address,
        input  d_pmem_wdata,
        output d_pmem_rdata,
        output d_pmem_resp,
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    // Environment view: cache controllers plus memory model.
    modport master (
        output i_pmem_read,
        output i_pmem_address,
        input  i_pmem_rdata,
        input  i_pmem_resp,
        output d_pmem_read,
        output d_pmem_write,
        output d_pmem_address,
        output d_pmem_wdata,
        input  d_pmem_rdata,
        input  d_pmem_resp,
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port
// between the I-cache and D-cache line-transfer controllers.
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last_d;
    logic              r_cmd_read;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [LINE_W-1:0] r_cmd_wdata;

    logic w_req_i;
    logic w_req_d;
    logic w_grant_i;
    logic w_grant_d;
    logic w_serve_i;
    logic w_serve_d;
    logic w_serving;
    logic w_done;

    assign w_req_i = bus.i_pmem_read;
    assign w_req_d = bus.d_pmem_read | bus.d_pmem_write;

    // On a tie the side that did not go last wins.
    assign w_grant_i = (r_state == S_IDLE) & w_req_i
                     & (~w_req_d | r_last_d);
    assign w_grant_d = (r_state == S_IDLE) & w_req_d
                     & ~w_grant_i;

    assign w_serve_i = (r_state == S_SERVE_I);
    assign w_serve_d = (r_state == S_SERVE_D);
    assign w_serving = w_serve_i | w_serve_d;
    assign w_done    = w_serving & bus.pmem_resp;

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_i) begin
                    w_state_nxt = S_SERVE_I;
                end else if (w_grant_d) begin
                    w_state_nxt = S_SERVE_D;
                end
            end
            S_SERVE_I,
            S_SERVE_D: begin
                if (bus.pmem_resp) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin history: remembers who finished last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b1;
        end else if (w_done) begin
            r_last_d <= w_serve_d;
        end
    end

    // Command latch: captured on grant, cleared on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_grant_i) begin
            r_cmd_read  <= 1'b1;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= bus.i_pmem_address;
            r_cmd_wdata <= '0;
        end else if (w_grant_d) begin
            // Write-back takes priority over a simultaneous fill.
            r_cmd_read  <= bus.d_pmem_read & ~bus.d_pmem_write;
            r_cmd_write <= bus.d_pmem_write;
            r_cmd_addr  <= bus.d_pmem_address;
            r_cmd_wdata <= bus.d_pmem_wdata;
        end else if (w_done) begin
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end
    end

    // Memory side is driven only from the latched command.
    assign bus.pmem_read    = w_serving & r_cmd_read;
    assign bus.pmem_write   = w_serving & r_cmd_write;
    assign bus.pmem_address = w_serving ? r_cmd_addr : '0;
    assign bus.pmem_wdata   = w_serving ? r_cmd_wdata : '0;

    // Data fans out to both; resp alone qualifies it.
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
    assign bus.i_pmem_resp  = w_serve_i & bus.pmem_resp;
    assign bus.d_pmem_resp  = w_serve_d & bus.pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: round-robin order,
// command latching, release spacing, stray resp, reset.
module tb_pmem_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"}, bus.pmem_read, 1'b0);
        chk({tag, "_wr"}, bus.pmem_write, 1'b0);
        chk({tag, "_ir"}, bus.i_pmem_resp, 1'b0);
        chk({tag, "_dr"}, bus.d_pmem_resp, 1'b0);
    endtask

    // Wait for a command; gap = idle cycles seen before it.
    task automatic wait_cmd(output int gap);
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bus.pmem_read | bus.pmem_write) return;
            gap++;
        end
        chk("cmd_seen", bus.pmem_read | bus.pmem_write, 1'b1);
    endtask

    // Memory model: answer after lat cycles (lat >= 2).
    task automatic serve(input int lat,
                         input logic [127:0] data,
                         output logic gi,
                         output logic gd,
                         output logic rd,
                         output logic wr,
                         output logic [15:0] ad,
                         output logic [127:0] wd,
                         output int gap);
        wait_cmd(gap);
        rd = bus.pmem_read;
        wr = bus.pmem_write;
        ad = bus.pmem_address;
        wd = bus.pmem_wdata;
        chk("pre_ir", bus.i_pmem_resp, 1'b0);
        chk("pre_dr", bus.d_pmem_resp, 1'b0);
        repeat (lat - 2) begin
            @(negedge clk);
            #1;
            chk("hold_ad", bus.pmem_address, ad);
            chk("hold_rd", bus.pmem_read, rd);
        end
        @(negedge clk);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        #1;
        gi = bus.i_pmem_resp;
        gd = bus.d_pmem_resp;
        chk("i_rdata", bus.i_pmem_rdata, data);
        chk("d_rdata", bus.d_pmem_rdata, data);
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        #1;
        chk_quiet("release");
    endtask

    logic         gi, gd, rd, wr;
    logic [15:0]  ad;
    logic [127:0] wd;
    int           gap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
        #1;
        chk_quiet("rst_hold");
        chk("rst_ad", bus.pmem_address, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("rst_rel");
        chk("rel_ad", bus.pmem_address, 16'h0);

        // I only.
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        serve(3, {16{8'hA5}}, gi, gd, rd, wr, ad, wd, gap);
        bus.i_pmem_read = 1'b0;
        chk("t1_gap", gap, 0);
        chk("t1_rd", rd, 1'b1);
        chk("t1_ad", ad, 16'h1230);
        chk("t1_gi", gi, 1'b1);
        chk("t1_gd", gd, 1'b0);

        // Tie after reset: I first, then D.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h0040;
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h8000;
        bus.d_pmem_wdata   = 128'h1;
        serve(2, 128'h11, gi, gd, rd, wr, ad, wd, gap);
        bus.i_pmem_read = 1'b0;
        chk("t2a_gi", gi, 1'b1);
        chk("t2a_ad", ad, 16'h0040);
        serve(2, 128'h22, gi, gd, rd, wr, ad, wd, gap);
        bus.d_pmem_write = 1'b0;
        chk("t2b_gap", gap, 1);
        chk("t2b_gd", gd, 1'b1);
        chk("t2b_gi", gi, 1'b0);
        chk("t2b_wr", wr, 1'b1);
        chk("t2b_rd", rd, 1'b0);
        chk("t2b_ad", ad, 16'h8000);
        chk("t2b_wd", wd, 128'h1);

        // Continuous contention: I, D, I, D.
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h0300;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h0400;
        for (int t = 0; t < 4; t++) begin
            serve(3, 128'h100 + 128'(t), gi, gd, rd, wr, ad, wd, gap);
            chk($sformatf("t3_gi%0d", t), gi, (t % 2) == 0);
            chk($sformatf("t3_gd%0d", t), gd, (t % 2) == 1);
            chk($sformatf("t3_ad%0d", t), ad,
                ((t % 2) == 0) ? 16'h0300 : 16'h0400);
            chk($sformatf("t3_gap%0d", t), gap, 1);
        end
        bus.i_pmem_read = 1'b0;

        // D inputs change and drop mid-service.
        bus.d_pmem_address = 16'h0100;
        wait_cmd(gap);
        chk("t4_ad0", bus.pmem_address, 16'h0100);
        chk("t4_rd0", bus.pmem_read, 1'b1);
        @(negedge clk);
        bus.d_pmem_address = 16'h0200;
        #1;
        chk("t4_ad1", bus.pmem_address, 16'h0100);
        @(negedge clk);
        bus.d_pmem_read = 1'b0;
        #1;
        chk("t4_ad2", bus.pmem_address, 16'h0100);
        chk("t4_rd2", bus.pmem_read, 1'b1);
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t4_dr", bus.d_pmem_resp, 1'b1);
        chk("t4_ir", bus.i_pmem_resp, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        chk_quiet("t4_rel");

        // D read and write together: write wins.
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h0500;
        bus.d_pmem_wdata   = 128'hDEAD;
        serve(2, 128'h0, gi, gd, rd, wr, ad, wd, gap);
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        chk("t5_wr", wr, 1'b1);
        chk("t5_rd", rd, 1'b0);
        chk("t5_wd", wd, 128'hDEAD);

        // Stray resp while idle.
        repeat (2) @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t6_ir", bus.i_pmem_resp, 1'b0);
        chk("t6_dr", bus.d_pmem_resp, 1'b0);
        @(negedge clk);
        #1;
        chk_quiet("t6_idle");
        bus.pmem_resp = 1'b0;

        // Reset during SERVE_D, then I wins the tie.
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h0600;
        wait_cmd(gap);
        chk("t7_wr", bus.pmem_write, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_async_wr", bus.pmem_write, 1'b0);
        chk("t7_async_rd", bus.pmem_read, 1'b0);
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h0700;
        @(negedge clk);
        rst_n = 1'b1;
        serve(2, 128'h7, gi, gd, rd, wr, ad, wd, gap);
        bus.i_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        chk("t7_gi", gi, 1'b1);
        chk("t7_ad", ad, 16'h0700);
        chk("t7_gap", gap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
